pulse_voice: RTL and testbench
==============================

PULSE_VOICE -- requirements
Module: pulse_voice

Interface
REQ-001 The parameter PHASE_WIDTH shall default to 32 and set the phase accumulator width in bits (minimum 4).
REQ-002 The parameter OUT_WIDTH shall default to 9 and set the width of the amplitude, volume and output buses.
REQ-003 The parameter DECAY_STEP shall default to 1 and set the envelope decrement applied per decay event while in PLAY.
REQ-004 The parameter RELEASE_STEP shall default to 16 and set the envelope decrement applied per tick while in RELEASE.
REQ-005 The port i_clk shall be a 1-bit input and the only clock; all state is updated on its rising edge.
REQ-006 The port i_rst shall be a 1-bit input, a synchronous active-high reset.
REQ-007 The port i_tick_stb shall be a 1-bit input, a one-cycle frame-tick strobe that paces the envelope and length counter.
REQ-008 The port i_note_valid shall be a 1-bit input, a one-cycle note-trigger strobe; it is accepted on any cycle.
REQ-009 The port i_note_off shall be a 1-bit input, a one-cycle release request.
REQ-010 The port i_phase_delta shall be a PHASE_WIDTH-bit input, the per-cycle phase increment.
REQ-011 The port i_duty shall be a 2-bit input selecting the duty cycle.
REQ-012 The port i_volume shall be an OUT_WIDTH-bit input, the initial envelope level.
REQ-013 The port i_decay_period shall be a 4-bit input giving the number of ticks per decay event minus 1.
REQ-014 The port i_length shall be an 8-bit input giving the note length in ticks; 0 means sustain until i_note_off.
REQ-015 The port o_output shall be an OUT_WIDTH-bit registered output carrying the pulse amplitude.
REQ-016 The port o_frame_pulse shall be a 1-bit output equal to the phase MSB.
REQ-017 The port o_active shall be a 1-bit output, high whenever the state is not IDLE.

Function
REQ-018 The state machine shall have three states: IDLE, PLAY and RELEASE.
REQ-019 When i_note_valid is high, on the next edge: i_phase_delta, i_duty, i_decay_period and i_length are latched; phase is set to 0; envelope is set to i_volume; the decay-tick counter is cleared; state is set to PLAY. This applies from any state, i.e. a trigger restarts a note already playing.
REQ-020 In PLAY and RELEASE the phase shall advance by the latched delta every cycle, modulo 2^PHASE_WIDTH; in IDLE the phase shall hold.
REQ-021 In PLAY, each i_tick_stb shall increment the decay-tick counter; when the counter reaches the latched decay_period it shall wrap to 0 and the envelope shall decrease by DECAY_STEP, saturating at 0.
REQ-022 In PLAY with latched length nonzero, each i_tick_stb shall decrement the length counter; when it steps from 1 to 0 the state shall go to RELEASE on the same edge.
REQ-023 In PLAY, i_note_off shall move the state to RELEASE.
REQ-024 In RELEASE, each i_tick_stb shall decrease the envelope by RELEASE_STEP, saturating at 0.
REQ-025 In RELEASE, the state shall go to IDLE on the edge on which the envelope becomes 0, or at once if the envelope is already 0.
REQ-026 The duty window shall be decoded from phase bits P = phase[MSB:MSB-2]:
  - 00: high when P == 111 (12.5%)
  - 01: high when P[2:1] == 11 (25%)
  - 10: high when P[2] == 1 (50%)
  - 11: high when P[2:1] != 00 (75%)
REQ-027 o_output shall be registered: it equals the envelope while the window is high and the state is not IDLE, and 0 otherwise; it lags phase and envelope by 1 cycle.
REQ-028 A trigger at edge N shall give o_output reflecting phase 0 and the new envelope at edge N+1.
REQ-029 Simultaneous events shall be resolved as follows:
  - i_note_valid beats i_note_off and i_tick_stb; that tick is ignored.
  - i_note_off with i_tick_stb in PLAY goes to RELEASE; the tick does no decay and no length decrement.
  - i_note_off in IDLE or RELEASE has no effect.
REQ-030 i_tick_stb in IDLE shall have no effect.

Reset
REQ-031 When i_rst is high, the next edge shall set: state IDLE, phase 0, envelope 0, all counters 0, latched fields 0, o_output 0, o_active 0.
REQ-032 i_rst shall take priority over every other input, including mid-note and on the same cycle as i_note_valid.

Structure
REQ-033 A shared package pulse_voice_pkg shall hold the state encoding, the 2-bit duty encodings and the length-0-is-sustain constant.
REQ-034 Envelope level, decay-tick counter and saturating subtraction shall sit in one sub-module, pulse_envelope; phase, FSM, length counter and output register shall stay in pulse_voice.

Verification
REQ-035 Duty sweep: defaults, delta 2^28 (16-cycle period), volume 100, length 0, duty 00/01/10/11 -> o_output = 100 for 2/4/8/12 of every 16 cycles and 0 otherwise; o_frame_pulse has a 16-cycle period.
REQ-036 Decay: volume 10, decay_period 1, 6 ticks -> envelope reads 10, 10→9, 9→8, then 7, with one decrement per 2 ticks; from volume 1, further ticks keep it at 0 (no wrap).
REQ-037 Length and release: length 3, volume 40, 3 ticks -> RELEASE after tick 3; envelope 24, 8, 0 over the next 3 ticks; o_active falls on the edge where the envelope reaches 0.
REQ-038 Collisions: i_note_valid with i_tick_stb and i_note_off in the same cycle during RELEASE -> PLAY, envelope = new i_volume, phase 0, length unchanged by the tick.
REQ-039 Reset mid-note: i_rst asserted in PLAY at phase 0x4000_0000 -> after the next edge o_output 0, o_active 0, phase 0; a later trigger plays normally.
REQ-040 Parameter corner: PHASE_WIDTH 4, OUT_WIDTH 4, delta 1, duty 10 -> o_output high for 8 of every 16 cycles; the phase wraps from 15 to 0 with no glitch.

Source files
------------

// File: rtl/pulse_voice_pkg.sv
// Shared constants for the pulse voice: FSM state codes, duty selections,
// the sustain length code and the duty-window decoder.
package pulse_voice_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [1:0] DUTY_12P5 = 2'b00;
    localparam logic [1:0] DUTY_25   = 2'b01;
    localparam logic [1:0] DUTY_50   = 2'b10;
    localparam logic [1:0] DUTY_75   = 2'b11;

    // A latched length of zero means the note sustains until note-off
    localparam logic [7:0] LEN_SUSTAIN = 8'd0;

    function automatic logic duty_window(input logic [1:0] duty, input logic [2:0] p);
        logic hit;
        case (duty)
            DUTY_12P5: hit = (p == 3'b111);
            DUTY_25:   hit = (p[2:1] == 2'b11);
            DUTY_50:   hit = p[2];
            DUTY_75:   hit = (p[2:1] != 2'b00);
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pulse_envelope.sv
// Envelope level and decay-tick divider with saturating decrements.
// level_next exposes the value the level takes on the coming edge.
module pulse_envelope
    import pulse_voice_pkg::*;
#(
    parameter int OUT_WIDTH    = 9,
    parameter int DECAY_STEP   = 1,
    parameter int RELEASE_STEP = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] volume,
    input  logic [3:0]           decay_period,
    input  logic                 decay_tick,
    input  logic                 release_tick,
    output logic [OUT_WIDTH-1:0] level,
    output logic [OUT_WIDTH-1:0] level_next
);

    localparam int LEVEL_RANGE = 32'sd1 << OUT_WIDTH;

    // Steps at or beyond full scale clamp to full scale so they always empty the level
    localparam logic [OUT_WIDTH:0] DECAY_AMT = (DECAY_STEP >= LEVEL_RANGE)
        ? {1'b1, {OUT_WIDTH{1'b0}}} : (OUT_WIDTH+1)'(DECAY_STEP);
    localparam logic [OUT_WIDTH:0] RELEASE_AMT = (RELEASE_STEP >= LEVEL_RANGE)
        ? {1'b1, {OUT_WIDTH{1'b0}}} : (OUT_WIDTH+1)'(RELEASE_STEP);

    function automatic logic [OUT_WIDTH-1:0] sat_sub(input logic [OUT_WIDTH-1:0] a,
                                                      input logic [OUT_WIDTH:0]   b);
        logic [OUT_WIDTH:0] diff;
        diff = {1'b0, a} - b;
        if (diff[OUT_WIDTH]) begin
            return {OUT_WIDTH{1'b0}};
        end else begin
            return diff[OUT_WIDTH-1:0];
        end
    endfunction

    logic [OUT_WIDTH-1:0] level_r;
    logic [OUT_WIDTH-1:0] level_next_s;
    logic [3:0]           tick_cnt_r;
    logic [3:0]           tick_cnt_next_s;

    // Next level and divider count; a load beats any tick
    always_comb begin
        level_next_s    = level_r;
        tick_cnt_next_s = tick_cnt_r;
        if (load) begin
            level_next_s    = volume;
            tick_cnt_next_s = 4'd0;
        end else if (decay_tick) begin
            if (tick_cnt_r == decay_period) begin
                tick_cnt_next_s = 4'd0;
                level_next_s    = sat_sub(level_r, DECAY_AMT);
            end else begin
                tick_cnt_next_s = tick_cnt_r + 4'd1;
                level_next_s    = level_r;
            end
        end else if (release_tick) begin
            level_next_s    = sat_sub(level_r, RELEASE_AMT);
            tick_cnt_next_s = tick_cnt_r;
        end else begin
            level_next_s    = level_r;
            tick_cnt_next_s = tick_cnt_r;
        end
    end

    // Level and divider registers
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r    <= {OUT_WIDTH{1'b0}};
            tick_cnt_r <= 4'd0;
        end else begin
            level_r    <= level_next_s;
            tick_cnt_r <= tick_cnt_next_s;
        end
    end

    assign level      = level_r;
    assign level_next = level_next_s;

endmodule

// File: rtl/pulse_voice.sv
// Pulse-wave voice: phase accumulator, note FSM, length counter and a
// registered, envelope-scaled duty-cycle output.
module pulse_voice
    import pulse_voice_pkg::*;
#(
    parameter int PHASE_WIDTH  = 32,
    parameter int OUT_WIDTH    = 9,
    parameter int DECAY_STEP   = 1,
    parameter int RELEASE_STEP = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tick_stb,
    input  logic                   i_note_valid,
    input  logic                   i_note_off,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    input  logic [1:0]             i_duty,
    input  logic [OUT_WIDTH-1:0]   i_volume,
    input  logic [3:0]             i_decay_period,
    input  logic [7:0]             i_length,
    output logic [OUT_WIDTH-1:0]   o_output,
    output logic                   o_frame_pulse,
    output logic                   o_active
);

    localparam int MSB = PHASE_WIDTH - 1;

    logic [1:0]             state_r;
    logic [1:0]             state_next_s;
    logic [PHASE_WIDTH-1:0] phase_r;
    logic [PHASE_WIDTH-1:0] delta_r;
    logic [1:0]             duty_r;
    logic [3:0]             decay_period_r;
    logic [7:0]             length_r;
    logic [7:0]             len_cnt_r;
    logic [7:0]             len_cnt_next_s;
    logic [OUT_WIDTH-1:0]   out_r;
    logic [OUT_WIDTH-1:0]   env_level_s;
    logic [OUT_WIDTH-1:0]   env_next_s;
    logic                   decay_tick_s;
    logic                   release_tick_s;
    logic                   window_s;

    // A trigger swallows any simultaneous tick; note-off in PLAY swallows the tick too
    assign decay_tick_s   = (state_r == ST_PLAY) && i_tick_stb && !i_note_off && !i_note_valid;
    assign release_tick_s = (state_r == ST_RELEASE) && i_tick_stb && !i_note_valid;

    pulse_envelope #(
        .OUT_WIDTH    (OUT_WIDTH),
        .DECAY_STEP   (DECAY_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_env (
        .clk          (i_clk),
        .rst          (i_rst),
        .load         (i_note_valid),
        .volume       (i_volume),
        .decay_period (decay_period_r),
        .decay_tick   (decay_tick_s),
        .release_tick (release_tick_s),
        .level        (env_level_s),
        .level_next   (env_next_s)
    );

    // Note FSM and length countdown
    always_comb begin
        state_next_s   = state_r;
        len_cnt_next_s = len_cnt_r;
        if (i_note_valid) begin
            state_next_s   = ST_PLAY;
            len_cnt_next_s = i_length;
        end else begin
            case (state_r)
                ST_PLAY: begin
                    if (i_note_off) begin
                        state_next_s = ST_RELEASE;
                    end else if (i_tick_stb && (length_r != LEN_SUSTAIN)) begin
                        if (len_cnt_r == 8'd1) begin
                            len_cnt_next_s = 8'd0;
                            state_next_s   = ST_RELEASE;
                        end else begin
                            len_cnt_next_s = len_cnt_r - 8'd1;
                        end
                    end else begin
                        state_next_s = ST_PLAY;
                    end
                end
                ST_RELEASE: begin
                    // Leaves on the edge the level hits zero, or at once if already zero
                    if (env_next_s == {OUT_WIDTH{1'b0}}) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RELEASE;
                    end
                end
                ST_IDLE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, latched note fields and phase accumulator
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            len_cnt_r      <= 8'd0;
            phase_r        <= {PHASE_WIDTH{1'b0}};
            delta_r        <= {PHASE_WIDTH{1'b0}};
            duty_r         <= 2'b00;
            decay_period_r <= 4'd0;
            length_r       <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            len_cnt_r <= len_cnt_next_s;
            if (i_note_valid) begin
                delta_r        <= i_phase_delta;
                duty_r         <= i_duty;
                decay_period_r <= i_decay_period;
                length_r       <= i_length;
                phase_r        <= {PHASE_WIDTH{1'b0}};
            end else if (state_r != ST_IDLE) begin
                phase_r <= phase_r + delta_r;
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    assign window_s = duty_window(duty_r, phase_r[MSB -: 3]);

    // Output register, one cycle behind phase and envelope
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_r <= {OUT_WIDTH{1'b0}};
        end else if ((state_r != ST_IDLE) && window_s) begin
            out_r <= env_level_s;
        end else begin
            out_r <= {OUT_WIDTH{1'b0}};
        end
    end

    assign o_output      = out_r;
    assign o_frame_pulse = phase_r[MSB];
    assign o_active      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_pulse_voice.sv
// Directed bench for pulse_voice: default instance plus a 4-bit phase/out corner instance.
module tb_pulse_voice;
    import pulse_voice_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick, nv, noff;
    logic [31:0] delta;
    logic [1:0]  duty;
    logic [8:0]  vol;
    logic [3:0]  dp;
    logic [7:0]  length;
    logic [8:0]  out;
    logic        frame, active;

    logic        s_rst, s_nv;
    logic [3:0]  s_delta, s_vol, s_out;
    logic        s_frame, s_active;

    int tests = 0;
    int fails = 0;
    int highs, thr, c;
    int exp_out;
    int dec_exp [6] = '{10, 9, 9, 8, 8, 7};
    int duty_cnt[4] = '{2, 4, 8, 12};

    pulse_voice dut (
        .i_clk(clk), .i_rst(rst), .i_tick_stb(tick), .i_note_valid(nv), .i_note_off(noff),
        .i_phase_delta(delta), .i_duty(duty), .i_volume(vol), .i_decay_period(dp),
        .i_length(length), .o_output(out), .o_frame_pulse(frame), .o_active(active)
    );

    pulse_voice #(.PHASE_WIDTH(4), .OUT_WIDTH(4)) dut_small (
        .i_clk(clk), .i_rst(s_rst), .i_tick_stb(tick), .i_note_valid(s_nv), .i_note_off(noff),
        .i_phase_delta(s_delta), .i_duty(duty), .i_volume(s_vol), .i_decay_period(dp),
        .i_length(length), .o_output(s_out), .o_frame_pulse(s_frame), .o_active(s_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; nv = 1'b0; noff = 1'b0; delta = 32'd0; duty = 2'b00;
        vol = 9'd0; dp = 4'd0; length = 8'd0;
        s_rst = 1'b1; s_nv = 1'b0; s_delta = 4'd0; s_vol = 4'd0;
        cyc(2);
        rst = 1'b0; s_rst = 1'b0;
        check("rst_out", out, 0);
        check("rst_active", active, 0);
        check("rst_frame", frame, 0);
        check("rst_small_out", s_out, 0);

        // Duty sweep, 16-cycle period
        for (int d = 0; d < 4; d++) begin
            duty = d[1:0]; delta = 32'h1000_0000; vol = 9'd100; length = 8'd0; dp = 4'd15;
            nv = 1'b1; cyc(1); nv = 1'b0;
            check($sformatf("duty%0d_active", d), active, 1);
            thr = (d == 0) ? 14 : (d == 1) ? 12 : (d == 2) ? 8 : 4;
            highs = 0;
            for (int k = 1; k <= 16; k++) begin
                cyc(1);
                c = (k - 1) % 16;
                exp_out = (c >= thr) ? 100 : 0;
                check($sformatf("duty%0d_out_k%0d", d, k), out, exp_out);
                check($sformatf("duty%0d_frame_k%0d", d, k), frame, ((k % 16) >= 8) ? 1 : 0);
                if (out == 9'd100) highs++;
            end
            check($sformatf("duty%0d_highs", d), highs, duty_cnt[d]);
        end

        // Decay: one decrement per two ticks
        delta = 32'd0; vol = 9'd10; dp = 4'd1; length = 8'd0;
        nv = 1'b1; cyc(1); nv = 1'b0;
        check("decay_load", dut.env_level_s, 10);
        tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check($sformatf("decay_t%0d", i + 1), dut.env_level_s, dec_exp[i]);
        end
        tick = 1'b0;
        vol = 9'd1; dp = 4'd0;
        nv = 1'b1; cyc(1); nv = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check($sformatf("decay_sat_t%0d", i + 1), dut.env_level_s, 0);
        end
        tick = 1'b0;
        check("decay_sat_active", active, 1);

        // Length 3 then release by 16 per tick
        vol = 9'd40; length = 8'd3; dp = 4'd15; delta = 32'h1000_0000; duty = 2'b11;
        nv = 1'b1; cyc(1); nv = 1'b0;
        tick = 1'b1;
        cyc(1); check("len_t1_state", dut.state_r, ST_PLAY);
        cyc(1); check("len_t2_state", dut.state_r, ST_PLAY);
        cyc(1); check("len_t3_state", dut.state_r, ST_RELEASE);
        check("len_t3_env", dut.env_level_s, 40);
        cyc(1); check("rel_t1_env", dut.env_level_s, 24); check("rel_t1_active", active, 1);
        cyc(1); check("rel_t2_env", dut.env_level_s, 8);  check("rel_t2_active", active, 1);
        cyc(1); check("rel_t3_env", dut.env_level_s, 0);  check("rel_t3_active", active, 0);
        tick = 1'b0;
        cyc(1); check("rel_idle_out", out, 0);

        // Collisions
        vol = 9'd100; length = 8'd0; dp = 4'd15;
        nv = 1'b1; cyc(1); nv = 1'b0;
        noff = 1'b1; cyc(1); noff = 1'b0;
        check("col_release", dut.state_r, ST_RELEASE);
        tick = 1'b1; cyc(1); tick = 1'b0;
        check("col_rel_env", dut.env_level_s, 84);
        vol = 9'd50; length = 8'd5; dp = 4'd0;
        nv = 1'b1; tick = 1'b1; noff = 1'b1; cyc(1); nv = 1'b0;
        check("col_state", dut.state_r, ST_PLAY);
        check("col_env", dut.env_level_s, 50);
        check("col_phase", dut.phase_r, 0);
        check("col_len", dut.len_cnt_r, 5);
        cyc(1); tick = 1'b0;
        check("off_tick_state", dut.state_r, ST_RELEASE);
        check("off_tick_env", dut.env_level_s, 50);
        check("off_tick_len", dut.len_cnt_r, 5);
        cyc(1); noff = 1'b0;
        check("off_in_rel_state", dut.state_r, ST_RELEASE);
        check("off_in_rel_env", dut.env_level_s, 50);
        vol = 9'd0; length = 8'd0;
        nv = 1'b1; cyc(1); nv = 1'b0;
        noff = 1'b1; cyc(1); noff = 1'b0;
        check("zero_rel_state", dut.state_r, ST_RELEASE);
        cyc(1);
        check("zero_rel_idle", active, 0);

        // Reset mid-note, colliding with a trigger
        vol = 9'd100; length = 8'd0; dp = 4'd15; delta = 32'h1000_0000; duty = 2'b10;
        nv = 1'b1; cyc(1); nv = 1'b0;
        cyc(4);
        check("mid_phase", dut.phase_r, 32'h4000_0000);
        rst = 1'b1; nv = 1'b1; cyc(1); rst = 1'b0; nv = 1'b0;
        check("mid_rst_out", out, 0);
        check("mid_rst_active", active, 0);
        check("mid_rst_phase", dut.phase_r, 0);
        check("mid_rst_env", dut.env_level_s, 0);
        nv = 1'b1; cyc(1); nv = 1'b0;
        cyc(8); check("post_rst_k8", out, 0);
        cyc(1); check("post_rst_k9", out, 100);

        // Narrow instance: 4-bit phase wraps every 16 cycles
        duty = 2'b10; s_delta = 4'd1; s_vol = 4'd9;
        s_nv = 1'b1; cyc(1); s_nv = 1'b0;
        highs = 0;
        for (int k = 1; k <= 32; k++) begin
            cyc(1);
            c = (k - 1) % 16;
            check($sformatf("small_out_k%0d", k), s_out, (c >= 8) ? 9 : 0);
            check($sformatf("small_frame_k%0d", k), s_frame, ((k % 16) >= 8) ? 1 : 0);
            if ((k % 16) == 0) check($sformatf("small_wrap_k%0d", k), dut_small.phase_r, 0);
            if (s_out == 4'd9) highs++;
        end
        check("small_highs", highs, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
